flash_loader: RTL

- Initiator side of the datapath's flash write port: drives flash_en / flash_addr / flash_data to preload instruction/data memory before the core runs.
- Consumes a byte stream from a serial receiver over a valid/ready handshake, packs bytes little-endian into WIDTH-bit words and issues one write strobe per word.
- Holds the core via cpu_hold while loading.

---
 rtl/flash_loader_pkg.sv | 24 ++
 rtl/flash_loader_word_packer.sv | 56 +++++
 rtl/flash_loader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/flash_loader_pkg.sv
// ----------------------------------------------------------------------------
// flash_loader_pkg
// Shared definitions for the flash loader: FSM state type and the length
// header size. Build option: FLASH_LOADER_CHECKSUM_EN adds the CHECK state.
// ----------------------------------------------------------------------------
package flash_loader_pkg;

    // Number of bytes in the word-count header that precedes the payload.
    localparam int LOADER_LEN_BYTES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
`ifdef FLASH_LOADER_CHECKSUM_EN
        ,
        ST_CHECK  = 3'd6
`endif
    } flash_loader_state_t;

endpackage

// File: rtl/flash_loader_word_packer.sv
// ----------------------------------------------------------------------------
// word_packer
// Packs an accepted byte stream little-endian into WIDTH-bit words.
//   clk, rst     : clock, asynchronous active-low reset
//   clear        : restart packing at byte lane 0
//   accept       : a byte is transferred this cycle
//   byte_in      : the byte being transferred
//   word_full    : this accepted byte completes the word
//   word_next    : packed word including the byte currently on byte_in
// ----------------------------------------------------------------------------
module word_packer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic [7:0]       byte_in,
    output logic             word_full,
    output logic [WIDTH-1:0] word_next
);
    localparam int BYTES = WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

    logic [WIDTH-1:0] word_q;
    logic [CNT_W-1:0] cnt;

    // Insert the incoming byte into its lane so the caller can capture the
    // completed word in the same cycle the last byte arrives.
    always_comb begin
        word_next = word_q;
        for (int k = 0; k < BYTES; k++) begin
            if (cnt == CNT_W'(k)) begin
                word_next[8*k +: 8] = byte_in;
            end
        end
    end

    assign word_full = accept && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
            cnt    <= '0;
        end else if (clear) begin
            word_q <= '0;
            cnt    <= '0;
        end else if (accept) begin
            word_q <= word_next;
            cnt    <= word_full ? '0 : cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/flash_loader.sv
// ----------------------------------------------------------------------------
// flash_loader
// Receives a length-prefixed byte stream and writes it word by word into
// memory through the flash write port, holding the core while loading.
// Build option: FLASH_LOADER_CHECKSUM_EN appends a one-byte modular checksum
// after the payload; a mismatch sets err.
//   clk, rst            : clock, asynchronous active-low reset
//   start               : begin a session (honoured in IDLE only)
//   rx_data/valid/ready : byte stream handshake
//   flash_en/addr/data  : one-cycle word write strobe, address, data
//   cpu_hold            : high while a session is active
//   done                : one-cycle pulse at session end
//   err                 : sticky (length clamped / bad checksum)
// ----------------------------------------------------------------------------
module flash_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  flash_en,
    output logic [ADDR_WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0]      flash_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);
    import flash_loader_pkg::*;

    localparam int LEN_W = 8 * LOADER_LEN_BYTES;
    localparam logic [LEN_W:0]      DEPTH_L = (LEN_W + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);

    flash_loader_state_t state;
    logic [7:0]          len_lo;
    // One bit wider than the address so a full DEPTH count is representable.
    logic [ADDR_WIDTH:0] n_words;
    logic [ADDR_WIDTH:0] word_cnt;
    logic                accept;
    logic [LEN_W:0]      len_req;
    logic                pack_clear;
    logic                pack_accept;
    logic                word_full;
    logic [WIDTH-1:0]    word_next;
`ifdef FLASH_LOADER_CHECKSUM_EN
    logic [7:0]          sum_q;
`endif

    assign accept      = rx_valid && rx_ready;
    assign len_req     = {1'b0, rx_data, len_lo};
    assign pack_clear  = (state == ST_IDLE) && start;
    assign pack_accept = accept && (state == ST_DATA);

    word_packer #(
        .WIDTH (WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pack_clear),
        .accept    (pack_accept),
        .byte_in   (rx_data),
        .word_full (word_full),
        .word_next (word_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            rx_ready   <= 1'b0;
            flash_en   <= 1'b0;
            flash_addr <= '0;
            flash_data <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            len_lo     <= '0;
            n_words    <= '0;
            word_cnt   <= '0;
`ifdef FLASH_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            // Strobes are single-cycle; they are re-raised only on entry
            // into WRITE / DONE.
            flash_en <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LEN_LO;
                        rx_ready <= 1'b1;
                        cpu_hold <= 1'b1;
                        err      <= 1'b0;
                        n_words  <= '0;
                        word_cnt <= '0;
`ifdef FLASH_LOADER_CHECKSUM_EN
                        sum_q    <= '0;
`endif
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len_lo <= rx_data;
                        state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        if (len_req > DEPTH_L) begin
                            n_words <= DEPTH_W;
                            err     <= 1'b1;
                        end else begin
                            n_words <= len_req[ADDR_WIDTH:0];
                        end
                        if (len_req == '0) begin
`ifdef FLASH_LOADER_CHECKSUM_EN
                            state <= ST_CHECK;
`else
                            state    <= ST_DONE;
                            rx_ready <= 1'b0;
                            done     <= 1'b1;
`endif
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
`ifdef FLASH_LOADER_CHECKSUM_EN
                        sum_q <= sum_q + rx_data;
`endif
                        if (word_full) begin
                            state      <= ST_WRITE;
                            rx_ready   <= 1'b0;
                            flash_en   <= 1'b1;
                            flash_addr <= word_cnt[ADDR_WIDTH-1:0];
                            flash_data <= word_next;
                        end
                    end
                end
                ST_WRITE: begin
                    word_cnt <= word_cnt + ONE_W;
                    if (word_cnt == n_words - ONE_W) begin
`ifdef FLASH_LOADER_CHECKSUM_EN
                        state    <= ST_CHECK;
                        rx_ready <= 1'b1;
`else
                        state <= ST_DONE;
                        done  <= 1'b1;
`endif
                    end else begin
                        state    <= ST_DATA;
                        rx_ready <= 1'b1;
                    end
                end
`ifdef FLASH_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) begin
                        if (rx_data != sum_q) begin
                            err <= 1'b1;
                        end
                        state    <= ST_DONE;
                        rx_ready <= 1'b0;
                        done     <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    cpu_hold <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    rx_ready <= 1'b0;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule
